// File: rtl/mc_path_gen.sv
// mc_path_gen: Monte Carlo asset-price path generator.
// Produces N paths x DAY days of W-bit prices in day-major order over a
// valid/ready stream. Each step moves a price up or down by price >> SHIFT,
// with the direction taken from a 16-bit Galois LFSR. Up steps saturate at
// the top of the price range.
// Build macro MC_PATH_GEN_ANTITHETIC_EN: generates paths as antithetic pairs
// (2k, 2k+1). The odd member always steps opposite to its even partner, and
// the LFSR advances once per pair.
module mc_path_gen #(
    parameter int N     = 128,
    parameter int DAY   = 8,
    parameter int SHIFT = 4,
    parameter int W     = 12
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [W-1:0]           s0,
    input  logic [15:0]            seed,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [W-1:0]           out_price,
    output logic [$clog2(N)-1:0]   out_idx,
    output logic [$clog2(DAY)-1:0] out_day,
    output logic                   out_last,
    output logic                   busy,
    output logic                   done
);
    localparam int            IW        = $clog2(N);
    localparam int            DW        = $clog2(DAY);
    localparam logic [IW-1:0] IDX_LAST  = IW'(N - 1);
    localparam logic [DW-1:0] DAY_LAST  = DW'(DAY - 1);
    localparam logic [15:0]   LFSR_INIT = 16'hACE1;
    localparam logic [15:0]   LFSR_TAPS = 16'hB400;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t        state_q, state_d;
    logic [IW-1:0] idx_q, idx_d;
    logic [DW-1:0] day_q, day_d;
    logic [15:0]   lfsr_q, lfsr_d;
    logic [W-1:0]  price_q [N];
`ifdef MC_PATH_GEN_ANTITHETIC_EN
    logic          bit_q, bit_d;
`endif

    logic          load;
    logic          hs;
    logic          dir_up;
    logic [W-1:0]  cur_price;
    logic [W-1:0]  delta;
    logic [W-1:0]  up_price;
    logic [W-1:0]  dn_price;
    logic [W:0]    up_wide;

    function automatic logic [15:0] lfsr_step(input logic [15:0] v);
        return v[0] ? ((v >> 1) ^ LFSR_TAPS) : (v >> 1);
    endfunction

    // Candidate next price for the addressed path. It is derived only from
    // registered state, so it holds steady while the consumer stalls.
    always_comb begin
        cur_price = price_q[idx_q];
        delta     = cur_price >> SHIFT;
        up_wide   = {1'b0, cur_price} + {1'b0, delta};
        up_price  = up_wide[W] ? {W{1'b1}} : up_wide[W-1:0];
        dn_price  = cur_price - delta;
`ifdef MC_PATH_GEN_ANTITHETIC_EN
        dir_up    = idx_q[0] ? ~bit_q : lfsr_q[0];
`else
        dir_up    = lfsr_q[0];
`endif
        out_price = dir_up ? up_price : dn_price;
    end

    // Next-state logic and handshake bookkeeping for IDLE -> RUN -> DONE.
    // NOTE: every output of this block is given a default first, so no path leaves a latch behind.
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        day_d     = day_q;
        lfsr_d    = lfsr_q;
`ifdef MC_PATH_GEN_ANTITHETIC_EN
        bit_d     = bit_q;
`endif
        load      = 1'b0;
        hs        = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                idx_d = '0;
                day_d = '0;
                if (start) begin
                    state_d = S_RUN;
                    load    = 1'b1;
                    lfsr_d  = (seed == 16'h0000) ? LFSR_INIT : seed;
                end
            end
            S_RUN: begin
                out_valid = 1'b1;
                busy      = 1'b1;
                if (out_ready) begin
                    hs = 1'b1;
`ifdef MC_PATH_GEN_ANTITHETIC_EN
                    if (!idx_q[0]) begin
                        bit_d  = lfsr_q[0];
                        lfsr_d = lfsr_step(lfsr_q);
                    end
`else
                    lfsr_d = lfsr_step(lfsr_q);
`endif
                    if (idx_q == IDX_LAST) begin
                        idx_d = '0;
                        if (day_q == DAY_LAST) begin
                            day_d   = '0;
                            state_d = S_DONE;
                        end else begin
                            day_d = day_q + DW'(1);
                        end
                    end else begin
                        idx_d = idx_q + IW'(1);
                    end
                end
            end
            S_DONE: begin
                busy    = 1'b1;
                done    = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign out_idx  = out_valid ? idx_q : '0;
    assign out_day  = out_valid ? day_q : '0;
    assign out_last = out_valid && (idx_q == IDX_LAST) && (day_q == DAY_LAST);

    // Control state register with synchronous reset.
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            day_q   <= '0;
            lfsr_q  <= LFSR_INIT;
`ifdef MC_PATH_GEN_ANTITHETIC_EN
            bit_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            day_q   <= day_d;
            lfsr_q  <= lfsr_d;
`ifdef MC_PATH_GEN_ANTITHETIC_EN
            bit_q   <= bit_d;
`endif
        end
    end

    // Price bank: bulk load on start, single-entry update on each handshake.
    // NOTE: the bank is cleared on reset, so an aborted run leaves no stale prices behind.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < N; i++) price_q[i] <= '0;
        end else if (load) begin
            for (int i = 0; i < N; i++) price_q[i] <= s0;
        end else if (hs) begin
            price_q[idx_q] <= out_price;
        end
    end

endmodule
